// File: rtl/irq_controller.sv
// Prioritised, maskable interrupt controller: edge-detects request lines, latches them
// as pending and presents the lowest-index enabled one to the core with its handler vector.
module irq_controller #(
   parameter int          N_SRC      = 8,
   parameter logic [15:0] VEC_BASE   = 16'h0040,
   parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [15:0]      cfg_wdata,
   input  logic             irq_ack,
   input  logic             irq_eoi,
   output logic             interrupt,
   output logic [15:0]      irq_vector,
   output logic [3:0]       irq_id,
   output logic [N_SRC-1:0] irq_pending,
   output logic [N_SRC-1:0] irq_enable,
   output logic [1:0]       o_dbg_state
);

   // Handshake: interrupt rises in IDLE and stays high (irq_id frozen) until a one-cycle
   // irq_ack; the core then owns the interrupt until a one-cycle irq_eoi returns to IDLE.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t           r_state;
   logic [N_SRC-1:0] r_src_q;
   logic [N_SRC-1:0] r_src_qq;
   logic [N_SRC-1:0] r_pending;
   logic [N_SRC-1:0] r_enable;
   logic             r_interrupt;
   logic [3:0]       r_irq_id;
   logic [15:0]      r_irq_vector;

   logic [N_SRC-1:0] w_edge;
   logic [N_SRC-1:0] w_sw_set;
   logic [N_SRC-1:0] w_w1c;
   logic [N_SRC-1:0] w_ack_clr;
   logic [N_SRC-1:0] w_id_hot;
   logic [N_SRC-1:0] w_enable_next;
   logic [N_SRC-1:0] w_pending_next;
   logic [N_SRC-1:0] w_eligible;
   logic             w_any;
   logic [3:0]       w_winner;
   logic [15:0]      w_vec;
   logic             w_cur_en;
   logic [15:0]      w_unused_wdata;

   assign w_unused_wdata = cfg_wdata;

   assign w_edge   = r_src_q & ~r_src_qq;
   assign w_sw_set = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[N_SRC-1:0] : '0;
   assign w_w1c    = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[N_SRC-1:0] : '0;
   assign w_enable_next = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[N_SRC-1:0] : r_enable;

   always_comb begin
      w_id_hot = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_id_hot[i] = (r_irq_id == 4'(i));
      end
   end

   assign w_ack_clr = (r_state == S_REQ && irq_ack) ? w_id_hot : '0;
   // Sets are OR-ed in after the clears so a same-cycle set always wins.
   assign w_pending_next = (r_pending & ~(w_w1c | w_ack_clr)) | w_edge | w_sw_set;
   assign w_eligible     = r_pending & r_enable;
   // A disable written in the same cycle as REQ already withdraws the request.
   assign w_cur_en       = |(w_enable_next & w_id_hot);

   always_comb begin
      w_any    = 1'b0;
      w_winner = 4'd0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_any    = 1'b1;
            w_winner = 4'(i);
         end
      end
   end

   assign w_vec = VEC_BASE + (16'(w_winner) * VEC_STRIDE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_src_q      <= '0;
         r_src_qq     <= '0;
         r_pending    <= '0;
         r_enable     <= '0;
         r_state      <= S_IDLE;
         r_interrupt  <= 1'b0;
         r_irq_id     <= 4'd0;
         r_irq_vector <= 16'd0;
      end else begin
         r_src_q   <= irq_src;
         r_src_qq  <= r_src_q;
         r_pending <= w_pending_next;
         r_enable  <= w_enable_next;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_irq_id     <= w_winner;
                  r_irq_vector <= w_vec;
                  r_interrupt  <= 1'b1;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (irq_ack) begin
                  r_interrupt <= 1'b0;
                  r_state     <= S_SERVICE;
               end else if (!w_cur_en) begin
                  r_interrupt <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_SERVICE: begin
               if (irq_eoi) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_interrupt <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign interrupt   = r_interrupt;
   assign irq_vector  = r_irq_vector;
   assign irq_id      = r_irq_id;
   assign irq_pending = r_pending;
   assign irq_enable  = r_enable;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: hand-computed expectations, plus an expected-id
// queue that is popped each time the core acknowledges a request.
module tb_irq_controller;

   localparam int N_SRC = 8;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_SERV = 2'd2;

   logic             clk;
   logic             reset;
   logic [N_SRC-1:0] irq_src;
   logic             cfg_we;
   logic [1:0]       cfg_addr;
   logic [15:0]      cfg_wdata;
   logic             irq_ack;
   logic             irq_eoi;
   logic             interrupt;
   logic [15:0]      irq_vector;
   logic [3:0]       irq_id;
   logic [N_SRC-1:0] irq_pending;
   logic [N_SRC-1:0] irq_enable;
   logic [1:0]       o_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] exp_q[$];

   irq_controller #(
      .N_SRC(N_SRC),
      .VEC_BASE(16'h0040),
      .VEC_STRIDE(16'h0004)
   ) dut (
      .clk(clk),
      .reset(reset),
      .irq_src(irq_src),
      .cfg_we(cfg_we),
      .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata),
      .irq_ack(irq_ack),
      .irq_eoi(irq_eoi),
      .interrupt(interrupt),
      .irq_vector(irq_vector),
      .irq_id(irq_id),
      .irq_pending(irq_pending),
      .irq_enable(irq_enable),
      .o_dbg_state(o_dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   // Driver tasks: inputs change just after a falling edge, outputs are sampled there too
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      step(1);
      cfg_we    = 1'b0;
      cfg_addr  = 2'd0;
      cfg_wdata = 16'd0;
   endtask

   // Scoreboard: the id being acknowledged must match the oldest expected id
   task automatic do_ack();
      logic [3:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
      check("ack_id", 32'(irq_id), 32'(e));
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      check("ack_int_low", 32'(interrupt), 32'd0);
      check("ack_state", 32'(o_dbg_state), 32'(ST_SERV));
   endtask

   task automatic do_eoi();
      irq_eoi = 1'b1;
      step(1);
      irq_eoi = 1'b0;
      check("eoi_state", 32'(o_dbg_state), 32'(ST_IDLE));
   endtask

   initial begin
      reset = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
      cfg_wdata = 16'd0; irq_ack = 1'b0; irq_eoi = 1'b0;
      step(2);
      reset = 1'b0;
      check("rst_int", 32'(interrupt), 32'd0);
      check("rst_id", 32'(irq_id), 32'd0);
      check("rst_vec", 32'(irq_vector), 32'd0);
      check("rst_pend", 32'(irq_pending), 32'd0);
      check("rst_en", 32'(irq_enable), 32'd0);
      check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));

      // Single source 2: latency and vector
      cfg_write(2'd0, 16'h0004);
      check("s1_en", 32'(irq_enable), 32'h04);
      irq_src = 8'h04;
      step(1);
      irq_src = 8'h00;
      step(1);
      check("s1_pend_e1", 32'(irq_pending), 32'h04);
      check("s1_int_e1", 32'(interrupt), 32'd0);
      step(1);
      check("s1_int_e2", 32'(interrupt), 32'd1);
      check("s1_id", 32'(irq_id), 32'd2);
      check("s1_vec", 32'(irq_vector), 32'h0048);
      check("s1_state", 32'(o_dbg_state), 32'(ST_REQ));
      exp_q.push_back(4'd2);
      do_ack();
      check("s1_pend_clr", 32'(irq_pending), 32'h00);
      do_eoi();

      // Sources 5 and 1 together: 1 first, then 5
      cfg_write(2'd0, 16'h00FF);
      irq_src = 8'h22;
      step(1);
      irq_src = 8'h00;
      step(1);
      check("s2_pend", 32'(irq_pending), 32'h22);
      step(1);
      check("s2_id_a", 32'(irq_id), 32'd1);
      check("s2_vec_a", 32'(irq_vector), 32'h0044);
      exp_q.push_back(4'd1);
      exp_q.push_back(4'd5);
      do_ack();
      check("s2_pend_left", 32'(irq_pending), 32'h20);
      do_eoi();
      check("s2_int_b1", 32'(interrupt), 32'd0);
      step(1);
      check("s2_int_b", 32'(interrupt), 32'd1);
      check("s2_vec_b", 32'(irq_vector), 32'h0054);
      do_ack();
      do_eoi();

      // Source 3 disabled while in REQ
      cfg_write(2'd2, 16'h0008);
      check("s3_swset", 32'(irq_pending), 32'h08);
      step(1);
      check("s3_int", 32'(interrupt), 32'd1);
      check("s3_id", 32'(irq_id), 32'd3);
      check("s3_vec", 32'(irq_vector), 32'h004C);
      cfg_write(2'd0, 16'h00F7);
      check("s3_int_drop", 32'(interrupt), 32'd0);
      check("s3_state", 32'(o_dbg_state), 32'(ST_IDLE));
      check("s3_pend_kept", 32'(irq_pending), 32'h08);
      step(1);
      check("s3_stay_idle", 32'(interrupt), 32'd0);
      cfg_write(2'd1, 16'h0008);
      check("s3_w1c", 32'(irq_pending), 32'h00);
      cfg_write(2'd0, 16'h00FF);

      // Source 4: new edge lands on the ack cycle, set wins
      irq_src = 8'h10;
      step(1);
      irq_src = 8'h00;
      step(1);
      check("s4_pend", 32'(irq_pending), 32'h10);
      irq_src = 8'h10;
      step(1);
      check("s4_int", 32'(interrupt), 32'd1);
      irq_src = 8'h00;
      exp_q.push_back(4'd4);
      exp_q.push_back(4'd4);
      do_ack();
      check("s4_pend_kept", 32'(irq_pending), 32'h10);
      do_eoi();
      step(1);
      check("s4_int_again", 32'(interrupt), 32'd1);
      do_ack();
      check("s4_pend_clr", 32'(irq_pending), 32'h00);
      do_eoi();

      // Source 0 pended while disabled, then cleared
      cfg_write(2'd0, 16'h0000);
      cfg_write(2'd2, 16'h0001);
      check("s5_pend", 32'(irq_pending), 32'h01);
      step(2);
      check("s5_no_int", 32'(interrupt), 32'd0);
      check("s5_idle", 32'(o_dbg_state), 32'(ST_IDLE));
      cfg_write(2'd1, 16'h0001);
      check("s5_w1c", 32'(irq_pending), 32'h00);
      cfg_write(2'd0, 16'h00FF);
      step(1);
      check("s5_no_int_en", 32'(interrupt), 32'd0);

      // Reset from SERVICE with everything pending
      cfg_write(2'd0, 16'h0080);
      cfg_write(2'd2, 16'h00FF);
      step(1);
      check("s6_id", 32'(irq_id), 32'd7);
      check("s6_vec", 32'(irq_vector), 32'h005C);
      exp_q.push_back(4'd7);
      do_ack();
      cfg_write(2'd2, 16'h0080);
      check("s6_pend_ff", 32'(irq_pending), 32'hFF);
      check("s6_serv", 32'(o_dbg_state), 32'(ST_SERV));
      reset = 1'b1;
      irq_src = 8'h01;
      step(1);
      reset = 1'b0;
      check("s6_rst_int", 32'(interrupt), 32'd0);
      check("s6_rst_id", 32'(irq_id), 32'd0);
      check("s6_rst_vec", 32'(irq_vector), 32'd0);
      check("s6_rst_pend", 32'(irq_pending), 32'd0);
      check("s6_rst_en", 32'(irq_enable), 32'd0);
      check("s6_rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
      step(1);
      check("s6_pend_r1", 32'(irq_pending), 32'h00);
      step(1);
      check("s6_pend_r2", 32'(irq_pending), 32'h01);
      cfg_write(2'd1, 16'h0001);
      step(3);
      check("s6_one_edge", 32'(irq_pending), 32'h00);
      cfg_write(2'd0, 16'h00FF);
      step(2);
      check("s6_no_int", 32'(interrupt), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
